// File: rtl/gate_driver_if.sv
// gate_driver_if
// Row-side consumer of the panel scan interface. Each accepted row strobe
// becomes a gate-driver sequence on the panel pins: optional STV start
// pulse (row 0 only), a CPV shift-clock pulse, an OE window and a quiet
// guard gap. Row completions, out-of-order rows and strobes that arrive
// while a row is still being driven are reported to the control plane.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   scan_active  scan frame in progress; strobes are ignored while low
//   scan_mode    1 = dummy scan (OE window doubled), 0 = normal readout
//   row_addr     row number, valid in the strobe cycle
//   reset_pulse  one-cycle row strobe
//   gd_stv       gate start pulse
//   gd_cpv       gate shift clock
//   gd_oe        gate output enable
//   busy         row sequence in progress
//   row_ack      one-cycle pulse in the last guard cycle of a finished row
//   rows_driven  completed rows in the current frame, saturating at 4095
//   seq_err      sticky: a row address arrived out of order
//   overrun      sticky: a strobe arrived while busy
module gate_driver_if #(
  parameter int T_STV   = 4,
  parameter int T_CPV   = 8,
  parameter int T_OE    = 16,
  parameter int T_GUARD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_active,
  input  logic        scan_mode,
  input  logic [11:0] row_addr,
  input  logic        reset_pulse,
  output logic        gd_stv,
  output logic        gd_cpv,
  output logic        gd_oe,
  output logic        busy,
  output logic        row_ack,
  output logic [11:0] rows_driven,
  output logic        seq_err,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STV   = 3'd1;
  localparam logic [2:0] S_CPV   = 3'd2;
  localparam logic [2:0] S_OE    = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] STV_LOAD       = CNT_W'(T_STV - 1);
  localparam logic [CNT_W-1:0] CPV_LOAD       = CNT_W'(T_CPV - 1);
  localparam logic [CNT_W-1:0] OE_LOAD_NORMAL = CNT_W'(T_OE - 1);
  localparam logic [CNT_W-1:0] OE_LOAD_DUMMY  = CNT_W'(2 * T_OE - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD     = CNT_W'(T_GUARD - 1);
  localparam logic [11:0]      ROW_MAX        = 12'hFFF;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             mode_dummy;
  logic [11:0]      expected_row;
  logic             scan_active_q;

  logic             scan_rise;
  logic             cnt_done;
  logic             finish_row;
  logic [11:0]      check_row;

  // A frame start clears the sequencing reference in the same edge, so a
  // strobe coinciding with it is checked against row 0. row_ack fires on the
  // edge that enters the last guard cycle; with a one-cycle guard that is the
  // OE exit edge itself.
  always_comb begin
    scan_rise  = scan_active & ~scan_active_q;
    cnt_done   = (cnt == '0);
    check_row  = scan_rise ? 12'd0 : expected_row;
    finish_row = scan_active &&
                 (((state == S_GUARD) && (cnt == CNT_ONE)) ||
                  ((state == S_OE) && cnt_done && (T_GUARD == 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      mode_dummy    <= 1'b0;
      expected_row  <= 12'd0;
      scan_active_q <= 1'b0;
      gd_stv        <= 1'b0;
      gd_cpv        <= 1'b0;
      gd_oe         <= 1'b0;
      busy          <= 1'b0;
      row_ack       <= 1'b0;
      rows_driven   <= 12'd0;
      seq_err       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      scan_active_q <= scan_active;
      row_ack       <= finish_row;

      if (scan_rise) begin
        seq_err      <= 1'b0;
        overrun      <= 1'b0;
        rows_driven  <= 12'd0;
        expected_row <= 12'd0;
      end

      // The row in flight is never disturbed by a late strobe; it is only flagged.
      if (reset_pulse && busy) begin
        overrun <= 1'b1;
      end

      if (finish_row && (rows_driven != ROW_MAX)) begin
        rows_driven <= rows_driven + 12'd1;
      end

      if (!scan_active) begin
        // Frame ended: abandon any row without acknowledging it.
        state  <= S_IDLE;
        cnt    <= '0;
        gd_stv <= 1'b0;
        gd_cpv <= 1'b0;
        gd_oe  <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (reset_pulse) begin
              mode_dummy   <= scan_mode;
              expected_row <= row_addr + 12'd1;
              if ((row_addr != check_row) && (row_addr != 12'd0)) begin
                seq_err <= 1'b1;
              end
              busy <= 1'b1;
              if (row_addr == 12'd0) begin
                state  <= S_STV;
                gd_stv <= 1'b1;
                cnt    <= STV_LOAD;
              end else begin
                state  <= S_CPV;
                gd_cpv <= 1'b1;
                cnt    <= CPV_LOAD;
              end
            end
          end
          S_STV: begin
            if (cnt_done) begin
              state  <= S_CPV;
              gd_stv <= 1'b0;
              gd_cpv <= 1'b1;
              cnt    <= CPV_LOAD;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          S_CPV: begin
            if (cnt_done) begin
              state  <= S_OE;
              gd_cpv <= 1'b0;
              gd_oe  <= 1'b1;
              cnt    <= mode_dummy ? OE_LOAD_DUMMY : OE_LOAD_NORMAL;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          S_OE: begin
            if (cnt_done) begin
              state <= S_GUARD;
              gd_oe <= 1'b0;
              cnt   <= GUARD_LOAD;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          S_GUARD: begin
            if (cnt_done) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state  <= S_IDLE;
            cnt    <= '0;
            gd_stv <= 1'b0;
            gd_cpv <= 1'b0;
            gd_oe  <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_driver_if.sv
// tb_gate_driver_if
// Self-checking bench for gate_driver_if. A timeline model predicts every
// output from the offset of the current cycle inside the accepted row; a
// compare process checks all outputs each cycle, and directed scenarios pin
// pulse widths, counters and flags against hand-computed numbers.
module tb_gate_driver_if;

  localparam int T_STV   = 4;
  localparam int T_CPV   = 8;
  localparam int T_OE    = 16;
  localparam int T_GUARD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_active = 1'b0;
  logic        scan_mode = 1'b0;
  logic [11:0] row_addr = 12'd0;
  logic        reset_pulse = 1'b0;
  logic        gd_stv, gd_cpv, gd_oe, busy, row_ack, seq_err, overrun;
  logic [11:0] rows_driven;

  int assertions = 0;
  int failures   = 0;

  gate_driver_if #(
    .T_STV(T_STV), .T_CPV(T_CPV), .T_OE(T_OE), .T_GUARD(T_GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_active(scan_active), .scan_mode(scan_mode),
    .row_addr(row_addr), .reset_pulse(reset_pulse),
    .gd_stv(gd_stv), .gd_cpv(gd_cpv), .gd_oe(gd_oe), .busy(busy),
    .row_ack(row_ack), .rows_driven(rows_driven), .seq_err(seq_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Timeline model: a row accepted at edge m_start occupies the m_len cycles
  // after it; phase boundaries follow from the configured durations.
  int          cyc;
  bit          m_active, m_row0, m_dummy, m_sa_q, m_seq, m_ovr, was_busy;
  int          m_start, m_len, m_rows, off, stv_cycles, oe_cycles;
  logic [11:0] m_exp_row;
  bit          e_stv, e_cpv, e_oe, e_busy, e_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_active = 0; m_sa_q = 0; m_seq = 0; m_ovr = 0; m_rows = 0;
      m_exp_row = 12'd0; m_start = 0; m_len = 0; m_row0 = 0; m_dummy = 0;
      e_stv = 0; e_cpv = 0; e_oe = 0; e_busy = 0; e_ack = 0;
    end else begin
      cyc = cyc + 1;
      was_busy = m_active;
      if (reset_pulse && was_busy) m_ovr = 1;
      if (scan_active && !m_sa_q) begin
        m_seq = 0; m_ovr = 0; m_rows = 0; m_exp_row = 12'd0;
      end
      m_sa_q = scan_active;
      if (was_busy && (!scan_active || cyc == m_start + m_len)) m_active = 0;
      if (!was_busy && scan_active && reset_pulse) begin
        if (row_addr != m_exp_row && row_addr != 12'd0) m_seq = 1;
        m_exp_row = row_addr + 12'd1;
        m_row0    = (row_addr == 12'd0);
        m_dummy   = scan_mode;
        m_start   = cyc;
        m_len     = (m_row0 ? T_STV : 0) + T_CPV + (m_dummy ? 2 : 1) * T_OE + T_GUARD;
        m_active  = 1;
      end
      e_stv = 0; e_cpv = 0; e_oe = 0; e_busy = 0; e_ack = 0;
      if (m_active) begin
        off        = cyc + 1 - m_start;
        stv_cycles = m_row0 ? T_STV : 0;
        oe_cycles  = m_dummy ? 2 * T_OE : T_OE;
        e_busy     = 1;
        if (off <= stv_cycles) e_stv = 1;
        else if (off <= stv_cycles + T_CPV) e_cpv = 1;
        else if (off <= stv_cycles + T_CPV + oe_cycles) e_oe = 1;
        if (off == m_len) begin
          e_ack = 1;
          if (m_rows < 4095) m_rows = m_rows + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_stv", gd_stv, e_stv);
      checkOutput("cyc_cpv", gd_cpv, e_cpv);
      checkOutput("cyc_oe", gd_oe, e_oe);
      checkOutput("cyc_busy", busy, e_busy);
      checkOutput("cyc_row_ack", row_ack, e_ack);
      checkOutput("cyc_rows_driven", rows_driven, m_rows);
      checkOutput("cyc_seq_err", seq_err, m_seq);
      checkOutput("cyc_overrun", overrun, m_ovr);
    end
  end

  // Pulse-width monitor: sampled once per cycle just after the edge.
  int run_stv, run_cpv, run_oe, run_busy, w_stv, w_cpv, w_oe, w_busy;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      run_stv = 0; run_cpv = 0; run_oe = 0; run_busy = 0;
      w_stv = 0; w_cpv = 0; w_oe = 0; w_busy = 0;
    end else begin
      if (gd_stv) run_stv++; else if (run_stv > 0) begin w_stv = run_stv; run_stv = 0; end
      if (gd_cpv) run_cpv++; else if (run_cpv > 0) begin w_cpv = run_cpv; run_cpv = 0; end
      if (gd_oe) run_oe++; else if (run_oe > 0) begin w_oe = run_oe; run_oe = 0; end
      if (busy) run_busy++; else if (run_busy > 0) begin w_busy = run_busy; run_busy = 0; end
    end
  end

  task automatic applyStimulus(input int row, input bit mode);
    @(negedge clk);
    row_addr    = 12'(row);
    scan_mode   = mode;
    reset_pulse = 1'b1;
    @(negedge clk);
    reset_pulse = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("wait_idle", busy, 0);
  endtask

  task automatic waitAck();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_ack) break;
    end
    checkOutput("wait_ack", row_ack, 1);
  endtask

  task automatic newFrame();
    @(negedge clk);
    scan_active = 1'b0;
    repeat (2) @(negedge clk);
    scan_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkRow0Widths(input string tag);
    checkOutput({tag, "_stv_w"}, w_stv, 4);
    checkOutput({tag, "_cpv_w"}, w_cpv, 8);
    checkOutput({tag, "_oe_w"}, w_oe, 16);
    checkOutput({tag, "_busy_w"}, w_busy, 32);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_stv", gd_stv, 0);
    checkOutput("rst_cpv", gd_cpv, 0);
    checkOutput("rst_oe", gd_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ack", row_ack, 0);
    checkOutput("rst_rows", rows_driven, 0);
    checkOutput("rst_flags", {seq_err, overrun}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    scan_active = 1'b1;
    repeat (2) @(negedge clk);

    // Row 0, normal mode
    applyStimulus(0, 1'b0);
    waitIdle();
    checkRow0Widths("row0");
    checkOutput("row0_rows", rows_driven, 1);
    checkOutput("row0_model_rows", m_rows, 1);
    checkOutput("row0_seq", seq_err, 0);

    // Rows 0..9 in dummy mode, strobes two cycles after each row_ack
    newFrame();
    for (int r = 0; r < 10; r++) begin
      applyStimulus(r, 1'b1);
      waitAck();
      @(negedge clk);
      checkOutput("dummy_oe_w", w_oe, 32);
      checkOutput("dummy_busy_w", w_busy, (r == 0) ? 48 : 44);
    end
    checkOutput("dummy_rows", rows_driven, 10);
    checkOutput("dummy_model_rows", m_rows, 10);
    checkOutput("dummy_seq", seq_err, 0);

    // Sequence 0, 1, 3, 4
    newFrame();
    applyStimulus(0, 1'b0);
    waitIdle();
    applyStimulus(1, 1'b0);
    waitIdle();
    checkOutput("seq_after1", seq_err, 0);
    applyStimulus(3, 1'b0);
    waitIdle();
    checkOutput("seq_after3", seq_err, 1);
    checkOutput("seq_row3_busy_w", w_busy, 28);
    checkOutput("seq_row3_cpv_w", w_cpv, 8);
    applyStimulus(4, 1'b0);
    waitIdle();
    checkOutput("seq_after4", seq_err, 1);
    checkOutput("seq_rows", rows_driven, 4);

    // Overrun strobe at k+10 during row 0
    newFrame();
    applyStimulus(0, 1'b0);
    repeat (8) @(negedge clk);
    applyStimulus(7, 1'b0);
    checkOutput("ovr_flag", overrun, 1);
    waitIdle();
    checkRow0Widths("ovr");
    checkOutput("ovr_rows", rows_driven, 1);
    checkOutput("ovr_seq", seq_err, 0);

    // scan_active falls during OE of row 5
    newFrame();
    applyStimulus(0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(9, 1'b0);
    waitIdle();
    applyStimulus(1, 1'b0); waitIdle();
    applyStimulus(2, 1'b0); waitIdle();
    applyStimulus(4, 1'b0); waitIdle();
    checkOutput("abort_pre_seq", seq_err, 1);
    checkOutput("abort_pre_ovr", overrun, 1);
    applyStimulus(5, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("abort_in_oe", gd_oe, 1);
    scan_active = 1'b0;
    @(negedge clk);
    checkOutput("abort_oe_low", gd_oe, 0);
    checkOutput("abort_busy_low", busy, 0);
    repeat (30) @(negedge clk);
    checkOutput("abort_rows", rows_driven, 4);
    scan_active = 1'b1;
    @(negedge clk);
    checkOutput("rise_rows", rows_driven, 0);
    checkOutput("rise_seq", seq_err, 0);
    checkOutput("rise_ovr", overrun, 0);

    // Asynchronous reset during CPV, then a nominal row 0
    repeat (2) @(negedge clk);
    applyStimulus(0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (gd_cpv) break;
      @(negedge clk);
    end
    checkOutput("wait_cpv", gd_cpv, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_stv", gd_stv, 0);
    checkOutput("arst_cpv", gd_cpv, 0);
    checkOutput("arst_oe", gd_oe, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_rows", rows_driven, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(0, 1'b0);
    waitIdle();
    checkRow0Widths("post_rst");
    checkOutput("post_rst_rows", rows_driven, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/gate_driver_if.md
# gate_driver_if

Row-side consumer of the panel scan interface. It takes row strobes and row addresses from the scan engines (dummy and normal) and converts each accepted strobe into the TFT gate-driver control sequence: STV, CPV and OE. It also reports row completion, sequencing errors and overruns back to the control plane. It sits between the scan engines and the panel gate-driver IC pins.

## Interface
Parameters:
- T_STV, 4: cycles STV is held high before CPV; applies to row 0 only.
- T_CPV, 8: cycles CPV is held high.
- T_OE, 16: cycles OE is held high in normal mode; doubled in dummy mode.
- T_GUARD, 4: cycles all outputs are low after OE.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_active  in  1  scan frame in progress. Strobes are ignored while low.
- scan_mode  in  1  1 = dummy scan, 0 = normal readout scan. Sampled with the strobe.
- row_addr  in  12  row number; valid in the strobe cycle.
- reset_pulse  in  1  row strobe, one cycle wide.
- gd_stv  out  1  gate start pulse.
- gd_cpv  out  1  gate shift clock.
- gd_oe  out  1  gate output enable.
- busy  out  1  row sequence in progress.
- row_ack  out  1  one-cycle pulse when a row finishes.
- rows_driven  out  12  count of completed rows in the current frame.
- seq_err  out  1  sticky: a row address was out of order.
- overrun  out  1  sticky: a strobe arrived while busy.

## Operation
- Clock and reset: single clock `clk`; `rst_n` is asynchronous, active-low. Every output is registered.
- Reset values: all outputs 0, state IDLE, expected_row = 0.
- States:
  - IDLE: wait for a strobe.
  - STV: gd_stv = 1 for T_STV cycles.
  - CPV: gd_cpv = 1 for T_CPV cycles.
  - OE: gd_oe = 1 for T_OE cycles, or 2·T_OE if the latched mode is dummy.
  - GUARD: all outputs low for T_GUARD cycles.
- A strobe is accepted when it is seen in IDLE with scan_active = 1.
  - The block latches row_addr and scan_mode.
  - Next state is STV if row_addr = 0, otherwise CPV.
- Transitions: STV → CPV → OE → GUARD → IDLE. Each state moves on when its down-counter reaches its terminal count; each state loads its own count on entry.
- Sequencing check:
  - On accept, if row_addr ≠ expected_row and row_addr ≠ 0, seq_err is set. The row is still driven.
  - expected_row becomes row_addr + 1, mod 4096: 4095 wraps to 0.
- Overrun: a strobe seen while busy sets overrun and is dropped. The row in progress is not disturbed.
- Strobe with scan_active = 0 in IDLE: ignored silently; no flags change.
- scan_active falling mid-row: the block aborts at the next edge. It goes to IDLE, forces gd_* low, drops busy, and does not pulse row_ack or increment rows_driven.
- scan_active rising edge (registered compare): clears seq_err, overrun and rows_driven, and sets expected_row = 0.
  - If the rising edge and an accepted strobe fall on the same edge, the clear happens first and then the strobe is checked against expected_row = 0.
- rows_driven increments on row_ack and saturates at 4095.
- Asynchronous reset mid-row: all outputs go to 0 immediately.

## Timing
- Strobe sampled at edge k. busy = 1 from k+1 to the end of the last GUARD cycle.
- Row 0, normal mode, default parameters:
  - gd_stv high in cycles k+1 .. k+4.
  - gd_cpv high in cycles k+5 .. k+12.
  - gd_oe high in cycles k+13 .. k+28.
  - Guard in cycles k+29 .. k+32; row_ack is high in cycle k+32.
  - Total 32 cycles.
- Row n > 0: no STV phase; gd_cpv starts at k+1; total 28 cycles.
- Dummy mode adds T_OE cycles: 48 cycles for row 0, 44 for n > 0.
- gd_stv, gd_cpv and gd_oe are mutually exclusive in every cycle.
- The earliest next accept is the cycle after the last GUARD cycle, i.e. one cycle after row_ack. A strobe coincident with row_ack counts as an overrun.

## Test plan
- Row 0, normal mode, defaults: gd_stv 4 cycles, gd_cpv 8, gd_oe 16, guard 4. row_ack at k+32; rows_driven = 1.
- Rows 0..9 in dummy mode, each strobe issued 2 cycles after the previous row_ack: each gd_oe is 32 cycles wide; rows_driven = 10; seq_err = 0.
- Row sequence 0, 1, 3: seq_err sets on row 3, and row 3 is still driven (28 cycles). The next strobe with row_addr = 4 raises no new error.
- Strobe at k+10 during row 0: overrun = 1; row 0 timing unchanged; rows_driven = 1.
- scan_active falls during the OE phase of row 5: outputs low on the next cycle, no row_ack, rows_driven unchanged. The next scan_active rising edge clears rows_driven, seq_err and overrun.
- rst_n asserted during CPV: all outputs 0 immediately. After release, a row 0 strobe produces the nominal 32-cycle sequence.
